seq_reduce_acc: RTL and testbench

- Parametrised, sequential successor of the N-input OR reducer.
- Accepts a frame of up to BEATS words of W bits over a valid/ready stream.
- Accumulates a bitwise reduction (OR or AND, optionally XOR) across the beats and presents a registered W-bit vector, a 1-bit whole-frame reduction and a beat count on an output valid/ready port.
- Sits between a word producer and control logic that needs "any/all bits set over a frame" flags.

---
 rtl/seq_reduce_pkg.sv | 37 +++
 rtl/word_reducer.sv | 39 +++
 rtl/seq_reduce_acc.sv | 147 ++++++++++++++
 tb/tb_seq_reduce_acc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_reduce_pkg.sv
// Shared definitions for the sequential bitwise reducer: mode encodings, FSM states,
// the internal operator type and the raw-mode to operator mapping.
// Optional XOR support is compiled in only when SEQ_REDUCE_XOR_EN is defined.
package seq_reduce_pkg;

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_OR,
        OP_AND,
        OP_XOR
    } op_e;

    // Reserved mode (and XOR when the feature is compiled out) falls back to OR.
    function automatic op_e mode_to_op(input logic [1:0] mode);
        op_e op;
        op = OP_OR;
        if (mode == MODE_AND) begin
            op = OP_AND;
        end
`ifdef SEQ_REDUCE_XOR_EN
        if (mode == MODE_XOR) begin
            op = OP_XOR;
        end
`endif
        return op;
    endfunction

endpackage

// File: rtl/word_reducer.sv
// Combinational word combiner: y = a op b, plus the scalar reduction of y with the same op.
// XOR path exists only when SEQ_REDUCE_XOR_EN is defined.
module word_reducer
    import seq_reduce_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  op_e          op_i,
    output logic [W-1:0] y_o,
    output logic         red_o
);

    // Word-wide combine of the two operands.
    always_comb begin
        y_o = a_i | b_i;
        case (op_i)
            OP_AND: y_o = a_i & b_i;
`ifdef SEQ_REDUCE_XOR_EN
            OP_XOR: y_o = a_i ^ b_i;
`endif
            default: y_o = a_i | b_i;
        endcase
    end

    // Collapse the combined word to one bit with the same operator.
    always_comb begin
        red_o = |y_o;
        case (op_i)
            OP_AND: red_o = &y_o;
`ifdef SEQ_REDUCE_XOR_EN
            OP_XOR: red_o = ^y_o;
`endif
            default: red_o = |y_o;
        endcase
    end

endmodule

// File: rtl/seq_reduce_acc.sv
// Sequential frame reducer: accumulates up to BEATS words with OR/AND (optionally XOR)
// and presents the registered vector, its one-bit reduction and the beat count.
// Define SEQ_REDUCE_XOR_EN to enable mode 2'b10 as XOR; otherwise it behaves as OR.
module seq_reduce_acc
    import seq_reduce_pkg::*;
#(
    parameter int unsigned   W     = 8,
    parameter int unsigned   BEATS = 4,
    localparam int unsigned  CW    = $clog2(BEATS + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    mode_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [W-1:0]  in_data_i,
    input  logic          in_last_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [W-1:0]  out_vec_o,
    output logic          out_bit_o,
    output logic [CW-1:0] out_count_o
);

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_e           op_q, op_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_vec_q, out_vec_d;
    logic          out_bit_q, out_bit_d;
    logic [CW-1:0] out_count_q, out_count_d;

    logic          accept;
    op_e           first_op;
    op_e           step_op;
    logic [W-1:0]  step_a;
    logic [W-1:0]  step_vec;
    logic          step_red;
    logic [CW-1:0] cnt_inc;

    assign in_ready_o = (state_q != S_DONE);
    assign accept     = in_valid_i && in_ready_o;
    assign first_op   = mode_to_op(mode_i);
    assign cnt_inc    = cnt_q + CW'(1);

    // On the first beat combine with the operator identity so the same reducer both loads
    // the accumulator and yields the correct whole-frame bit for single-beat frames.
    always_comb begin
        step_op = op_q;
        step_a  = acc_q;
        if (state_q == S_IDLE) begin
            step_op = first_op;
            step_a  = (first_op == OP_AND) ? {W{1'b1}} : {W{1'b0}};
        end
    end

    word_reducer #(
        .W (W)
    ) u_step (
        .a_i   (step_a),
        .b_i   (in_data_i),
        .op_i  (step_op),
        .y_o   (step_vec),
        .red_o (step_red)
    );

    // Next-state and result-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        out_bit_d   = out_bit_q;
        out_count_d = out_count_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d = step_vec;
                    cnt_d = CW'(1);
                    op_d  = first_op;
                    if (in_last_i || (BEATS == 1)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_vec_d   = step_vec;
                        out_bit_d   = step_red;
                        out_count_d = CW'(1);
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = step_vec;
                    cnt_d = cnt_inc;
                    if (in_last_i || (cnt_inc == CW'(BEATS))) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_vec_d   = step_vec;
                        out_bit_d   = step_red;
                        out_count_d = cnt_inc;
                    end
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= OP_OR;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_bit_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_bit_q   <= out_bit_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_vec_o   = out_vec_q;
    assign out_bit_o   = out_bit_q;
    assign out_count_o = out_count_q;

endmodule

// File: tb/tb_seq_reduce_acc.sv
// Bench for seq_reduce_acc: directed frames with literal expectations, then random traffic
// checked every cycle against a frame-level reference model.
module tb_seq_reduce_acc;

    localparam int W     = 8;
    localparam int BEATS = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_vec;
    logic          out_bit;
    logic [CW-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    seq_reduce_acc #(
        .W     (W),
        .BEATS (BEATS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_vec_o   (out_vec),
        .out_bit_o   (out_bit),
        .out_count_o (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    // op codes: 0 OR, 1 AND, 2 XOR
    function automatic int eff_op(input logic [1:0] m);
        if (m == 2'b01) return 1;
`ifdef SEQ_REDUCE_XOR_EN
        if (m == 2'b10) return 2;
`endif
        return 0;
    endfunction

    function automatic logic [W-1:0] combine(input int op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        if (op == 1) return a & b;
        if (op == 2) return a ^ b;
        return a | b;
    endfunction

    function automatic logic reduce_bit(input int op, input logic [W-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(v[i]);
        if (op == 1) return ones == W;
        if (op == 2) return ones % 2 == 1;
        return ones != 0;
    endfunction

    logic         m_valid = 1'b0;
    logic [W-1:0] m_vec   = '0;
    logic         m_bit   = 1'b0;
    int           m_cnt   = 0;
    int           m_n     = 0;
    int           m_op    = 0;
    logic [W-1:0] m_buf[BEATS];

    // Frame bookkeeping: collect accepted words, fold them when the frame closes.
    always @(posedge clk) begin
        int           op_now;
        logic [W-1:0] v;
        if (rst) begin
            m_valid <= 1'b0;
            m_n     <= 0;
            m_op    <= 0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (in_valid) begin
            op_now = (m_n == 0) ? eff_op(mode) : m_op;
            m_op       <= op_now;
            m_buf[m_n] <= in_data;
            if (in_last || (m_n + 1 == BEATS)) begin
                v = in_data;
                for (int i = 0; i < m_n; i++) v = combine(op_now, v, m_buf[i]);
                m_vec   <= v;
                m_bit   <= reduce_bit(op_now, v);
                m_cnt   <= m_n + 1;
                m_valid <= 1'b1;
                m_n     <= 0;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!m_valid));
        if (m_valid) begin
            chk("out_vec", 32'(out_vec), 32'(m_vec));
            chk("out_bit", 32'(out_bit), 32'(m_bit));
            chk("out_count", 32'(out_count), 32'(m_cnt));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic beat(input logic [1:0] m, input logic [W-1:0] d, input logic l);
        mode     = m;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] vec, input logic b,
                              input int cnt);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_latency"}, 32'(n), 32'(0));
        chk({name, "_vec"}, 32'(out_vec), 32'(vec));
        chk({name, "_bit"}, 32'(out_bit), 32'(b));
        chk({name, "_count"}, 32'(out_count), 32'(cnt));
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_vec", 32'(out_vec), 32'(0));
        chk("rst_out_bit", 32'(out_bit), 32'(0));
        chk("rst_out_count", 32'(out_count), 32'(0));

        // OR, full frame
        beat(2'b00, 8'h01, 1'b0);
        beat(2'b00, 8'h02, 1'b0);
        beat(2'b00, 8'h04, 1'b0);
        beat(2'b00, 8'h80, 1'b0);
        expect_out("or4", 8'h87, 1'b1, 4);

        // AND, mixed then all ones
        beat(2'b01, 8'hFF, 1'b0);
        beat(2'b01, 8'hF0, 1'b0);
        beat(2'b01, 8'h3C, 1'b0);
        beat(2'b01, 8'h30, 1'b0);
        expect_out("and4", 8'h30, 1'b0, 4);
        repeat (4) beat(2'b01, 8'hFF, 1'b0);
        expect_out("and_ff", 8'hFF, 1'b1, 4);

        // Short frame with consumer stall; offered beats must be ignored
        out_ready = 1'b0;
        beat(2'b00, 8'h00, 1'b0);
        beat(2'b00, 8'h00, 1'b1);
        expect_out("short", 8'h00, 1'b0, 2);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_vec", 32'(out_vec), 32'(0));
            chk("stall_count", 32'(out_count), 32'(2));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Mode change mid-frame has no effect
        beat(2'b01, 8'h0F, 1'b0);
        beat(2'b00, 8'h03, 1'b0);
        beat(2'b00, 8'h01, 1'b0);
        beat(2'b00, 8'h01, 1'b0);
        expect_out("mode_hold", 8'h01, 1'b0, 4);

        // Reset mid-frame discards the partial frame
        beat(2'b00, 8'h55, 1'b0);
        beat(2'b00, 8'h22, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        beat(2'b00, 8'h10, 1'b0);
        beat(2'b00, 8'h00, 1'b0);
        beat(2'b00, 8'h00, 1'b0);
        beat(2'b00, 8'h00, 1'b0);
        expect_out("after_rst", 8'h10, 1'b1, 4);

        // Mode 10: XOR when enabled, otherwise OR
        beat(2'b10, 8'hAA, 1'b0);
        beat(2'b10, 8'hFF, 1'b0);
        beat(2'b10, 8'h0F, 1'b0);
        beat(2'b10, 8'h00, 1'b0);
`ifdef SEQ_REDUCE_XOR_EN
        expect_out("xor", 8'h5A, 1'b0, 4);
`else
        expect_out("xor_as_or", 8'hFF, 1'b1, 4);
`endif

        // Random traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
